// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction prefetch unit feeding the decoder.
// Issues one word read at a time, reassembles the NSHIFT-bit reply beats
// into a 2*REG_BITS instruction word, and queues completed words in a small
// FIFO. The decoder drains the FIFO head and can step through the head's low
// byte NSHIFT bits at a time. A write_pc flushes the queue and redirects the
// fetch stream; a reply already in flight is still drained but thrown away.
module inst_prefetch #(
    parameter int NSHIFT   = 2,
    parameter int REG_BITS = 8,
    parameter int DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    // fetch request channel
    output logic                  fetch_req_valid,
    output logic [15:0]           fetch_req_addr,
    input  logic                  fetch_req_ready,

    // reply beats, LSB-first
    input  logic                  rx_data_valid,
    input  logic [NSHIFT-1:0]     rx_data,

    // instruction queue head towards the decoder
    output logic                  inst_valid,
    output logic [2*REG_BITS-1:0] inst,
    input  logic                  inst_done,

    // serial access to the head's low byte
    output logic [NSHIFT-1:0]     imm_data_in,
    input  logic                  next_imm_data,

    // decoder control
    input  logic                  block_prefetch,
    input  logic                  write_pc,
    input  logic [15:0]           new_pc,
    output logic                  prefetch_idle
);

    localparam int W         = 2 * REG_BITS;
    localparam int BEATS     = W / NSHIFT;
    localparam int IMM_STEPS = BEATS / 2;
    localparam int BW        = (BEATS > 1)     ? $clog2(BEATS)     : 1;
    localparam int KW        = (IMM_STEPS > 1) ? $clog2(IMM_STEPS) : 1;
    localparam int AW        = (DEPTH > 1)     ? $clog2(DEPTH)     : 1;
    localparam int CW        = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [15:0]     fetch_addr;
    logic [BW-1:0]   beat_cnt;
    logic [W-1:0]    shreg;
    logic            discard;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [KW-1:0]   imm_idx;

    logic            accept;
    logic            beat;
    logic            last_beat;
    logic [W-1:0]    word_nxt;
    logic            push;
    logic            pop;
    logic            can_issue;

    // Pointer advance with explicit wrap so any DEPTH >= 1 indexes safely.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1))
            return '0;
        else
            return p + AW'(1);
    endfunction

    // Event decode shared by the FSM, the datapath and the FIFO.
    always_comb begin
        accept    = (state == S_REQ) && fetch_req_ready;
        beat      = (state == S_RECV) && rx_data_valid;
        last_beat = beat && (beat_cnt == BW'(BEATS - 1));
        word_nxt  = {rx_data, shreg[W-1:NSHIFT]};
        // A flush in the same cycle as the final beat drops that word too.
        push      = last_beat && !discard && !write_pc;
        pop       = inst_done && inst_valid && !write_pc;
        // At most one request is outstanding, so one free slot is enough.
        can_issue = !block_prefetch && !write_pc && (count < CW'(DEPTH));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked process uses non-blocking assignments so all
        // registers update from the same pre-edge values.
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic; write_pc only blocks IDLE->REQ, it never
    // withdraws a raised request or cuts a reply short.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches
        // on paths that do not change state.
        state_nxt = state;
        unique case (state)
            S_IDLE: if (can_issue)       state_nxt = S_REQ;
            S_REQ:  if (fetch_req_ready) state_nxt = S_RECV;
            S_RECV: if (last_beat)       state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // Fetch address: a redirect overrides the post-acceptance increment.
    always_ff @(posedge clk) begin
        if (reset)
            fetch_addr <= '0;
        else if (write_pc)
            fetch_addr <= new_pc;
        else if (accept)
            fetch_addr <= fetch_addr + 16'd2;
    end

    // Beat counter and shift register; beats only count while receiving.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            shreg    <= '0;
        end else if (beat) begin
            shreg <= word_nxt;
            if (last_beat)
                beat_cnt <= '0;
            else
                beat_cnt <= beat_cnt + BW'(1);
        end
    end

    // Discard flag marks a reply made stale by a redirect; it lives until
    // that reply's final beat so the next word assembles cleanly.
    always_ff @(posedge clk) begin
        if (reset)
            discard <= 1'b0;
        else if (last_beat)
            discard <= 1'b0;
        else if (write_pc && ((state == S_RECV) || accept))
            discard <= 1'b1;
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy is tracked by the
        // pointers and count, and the output is masked while empty.
        if (push)
            mem[wr_ptr] <= word_nxt;
    end

    // FIFO pointers and occupancy; a flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (reset || write_pc) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Immediate index: restarts whenever the head changes, else steps with
    // wrap through the low byte.
    always_ff @(posedge clk) begin
        if (reset || write_pc || pop || (push && (count == '0)))
            imm_idx <= '0;
        else if (next_imm_data) begin
            if (imm_idx == KW'(IMM_STEPS - 1))
                imm_idx <= '0;
            else
                imm_idx <= imm_idx + KW'(1);
        end
    end

    // Output drive.
    always_comb begin
        fetch_req_valid = (state == S_REQ);
        fetch_req_addr  = fetch_addr;
        inst_valid      = (count != '0);
        inst            = inst_valid ? mem[rd_ptr] : '0;
        imm_data_in     = NSHIFT'(inst >> (NSHIFT * int'(imm_idx)));
        prefetch_idle   = (state == S_IDLE) && !discard;
    end

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction prefetch unit that supplies the decoder. It issues word-read requests at a 16-bit fetch address and reassembles each reply from NSHIFT-bit RX beats into an instruction word. Completed words go into a small FIFO, which the decoder drains through the `inst_valid`/`inst`/`inst_done` handshake. The unit also streams the current instruction's low byte serially on `imm_data_in`/`next_imm_data`, and it honours the decoder's `block_prefetch`/`write_pc` controls, reporting back on `prefetch_idle`.

## Interface
- `NSHIFT`, 2: bits per RX beat and per immediate step; must divide `REG_BITS`.
- `REG_BITS`, 8: register width. The instruction word is `2*REG_BITS` = 16 bits.
- `DEPTH`, 2: FIFO entries (power of two, ≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req_valid`  out  1  read request pending.
- `fetch_req_addr`  out  16  byte address of the requested word; equals the internal `fetch_addr`.
- `fetch_req_ready`  in  1  request accepted when `valid && ready`.
- `rx_data_valid`  in  1  one reply beat present.
- `rx_data`  in  NSHIFT  reply beat; the word arrives LSB-first.
- `inst_valid`  out  1  FIFO head is valid.
- `inst`  out  16  FIFO head word.
- `inst_done`  in  1  pops the head; ignored unless `inst_valid`.
- `imm_data_in`  out  NSHIFT  equals `inst[NSHIFT*k +: NSHIFT]`, where k is the immediate index.
- `next_imm_data`  in  1  advances k.
- `block_prefetch`  in  1  inhibits new requests.
- `write_pc`  in  1  flush and redirect.
- `new_pc`  in  16  redirect target, sampled when `write_pc` is high.
- `prefetch_idle`  out  1  no request pending or in flight.

## Operation
- Word assembly needs B = 2*REG_BITS/NSHIFT beats. A beat counter (0..B-1) shifts each beat in from the top.
  - On the beat where the counter is B-1, the assembled word is pushed into the FIFO, unless the discard flag is set.
- FSM states: IDLE, REQ, RECV.
  - IDLE→REQ when `!block_prefetch && !write_pc` and FIFO count + 1 ≤ DEPTH. At most one request is ever outstanding, so a push can never overflow the FIFO.
  - REQ: `fetch_req_valid`=1. On `fetch_req_ready`, go to RECV and set `fetch_addr` += 2 (mod 2^16).
  - RECV: on the last beat, go to IDLE. Beats seen in IDLE or REQ are ignored.
- `block_prefetch` only gates the IDLE→REQ transition. A REQ already raised stays raised.
- `write_pc` takes priority over every other event in the same cycle:
  - FIFO is emptied, k = 0, `fetch_addr` = `new_pc`. The `fetch_addr` += 2 update from a same-cycle acceptance is dropped.
  - In RECV, or in REQ with `fetch_req_ready`=1 that cycle: the discard flag is set. The reply is still consumed beat by beat and then dropped. The flag clears on the last beat.
  - In REQ without `fetch_req_ready`: the state stays REQ and `fetch_req_addr` shows `new_pc` from the next cycle. This is the only case where the address may change while valid is high.
  - A last beat arriving in the same cycle is discarded.
- Immediate index k (0..B/2-1) increments on `next_imm_data` and wraps to 0. It resets to 0 on pop, flush, or push into an empty FIFO.
- Simultaneous push and pop: both take effect and the count is unchanged. A push into an empty FIFO together with `inst_done` is impossible, because `inst_valid` is 0 in that cycle.
- `prefetch_idle` = (state == IDLE) && !discard.

## Timing
- Reset values: state IDLE, `fetch_addr`=0, FIFO empty, k=0, beat counter 0, discard 0.
  - Outputs after reset: `fetch_req_valid`=0, `fetch_req_addr`=0, `inst_valid`=0, `inst`=0, `imm_data_in`=0, `prefetch_idle`=1.
- Reset in mid-operation aborts everything. Any beats of an in-flight reply that arrive afterwards are ignored in IDLE.
- `fetch_req_valid` is registered: it rises one cycle after the IDLE→REQ condition is true. It drops the cycle after acceptance.
- Push on the last-beat cycle T gives `inst_valid`=1 at T+1 if the FIFO was empty.
- A pop at T shows the next head at T+1. The IDLE→REQ check uses the registered count.
- After `write_pc` at T: `inst_valid`=0 at T+1, and the next request is raised no earlier than T+2 with address `new_pc`.

## Test plan
- Reset, `block_prefetch`=0, ready tied 1, reply 0xA5C3 (beats 3,0,0,3,1,1,2,2) → request at address 0, then `inst`=0xA5C3 with `inst_valid`=1 the cycle after the 8th beat; the next request uses address 2.
- Hold `inst_done`=0 with DEPTH=2 → exactly two requests are issued, then `fetch_req_valid` stays 0. Pop one → a third request at address 4.
- Head 0x12B4, pulse `next_imm_data` 5 times → `imm_data_in` reads 0,1,3,2,0 (wraps); then `inst_done` → k=0 on the new head.
- `write_pc` with `new_pc`=0x0100 at RX beat 3 of a reply → the reply is drained and not pushed, FIFO is empty, the next request is to 0x0100, and `prefetch_idle` goes to 1 only after the 8th beat.
- `write_pc`(0x0040) in the same cycle as acceptance of the request to 0x0008 → that reply is discarded, and the next request is to 0x0040 (not 0x0042).
- `block_prefetch`=1 from reset → no request and `prefetch_idle`=1. Release → `fetch_req_valid`=1 one cycle later.
